reg_hazard_scoreboard: RTL and testbench
========================================

// Module: reg_hazard_scoreboard
// PURPOSE
//   Tracks in-flight writes to the 14-entry architectural register file and stalls
//   instruction issue while a source operand has a pending write (RAW hazard).
//   Sits between decode/issue and the register file. Issue bumps a per-register
//   pending count; the register-file write-back port decrements it.
//   The register file writes on the falling edge, so a same-cycle write-back
//   resolves the hazard without a stall.
// PARAMETERS
//   NUM_REGS  14  tracked registers (indices 0..NUM_REGS-1); higher indices never tracked
//   ADDR_W    4   register index width
//   CNT_W     2   pending-count width per register; max = 2**CNT_W-1
// PORTS
//   clk          in   1         clock; all state updates on rising edge
//   rst          in   1         synchronous, active-high reset
//   flush        in   1         clears all pending counts (pipeline flush)
//   issue_valid  in   1         decode presents an instruction this cycle
//   src1         in   ADDR_W    first source register index
//   src2         in   ADDR_W    second source register index
//   src2_used    in   1         1 = src2 is a real operand
//   issue_wb_en  in   1         instruction will write a register
//   issue_dest   in   ADDR_W    destination register index
//   writeBackEn  in   1         write-back this cycle (same signal the register file uses)
//   Dest_wb      in   ADDR_W    write-back destination index
//   stall        out  1         combinational; 1 = hold decode, instruction not accepted
//   issue_fire   out  1         combinational; issue_valid & ~stall
//   busy_vec     out  NUM_REGS  registered; bit i = count[i] != 0
//   wb_underflow out  1         registered, sticky; write-back to a register with count 0
// BEHAVIOUR
//   - State: count[i] (CNT_W bits) for i in 0..NUM_REGS-1; wb_underflow flag.
//   - Reset (rst=1 at posedge): all count=0, busy_vec=0, wb_underflow=0. rst beats flush.
//   - resolve(r) = writeBackEn & Dest_wb==r & count[r]==1   (final write lands this cycle)
//   - pend(r) = r<NUM_REGS & count[r]!=0 & ~resolve(r)
//   - stall = issue_valid & ( pend(src1) | (src2_used & pend(src2))
//             | (issue_wb_en & issue_dest<NUM_REGS & count[issue_dest]==max
//                & ~(writeBackEn & Dest_wb==issue_dest)) )
//   - The ~(writeBackEn & Dest_wb==issue_dest) term permits issue at max count
//     when a write-back to the same register lands that cycle.
//   - When issue_valid=0: stall=0 and issue_fire=0.
//   - Next state, per register i:
//       inc = issue_fire & issue_wb_en & issue_dest==i
//       dec = writeBackEn & Dest_wb==i & count[i]!=0
//       count[i] += inc - dec   (inc & dec in same cycle: unchanged)
//   - Indices >= NUM_REGS: issue and write-back are ignored; never cause stall.
//   - writeBackEn to register with count 0 (and no same-cycle inc): count stays 0;
//     wb_underflow set and held until rst. Flush does not clear it.
//   - flush=1 (rst=0): all count=0 next cycle, and issue/write-back that cycle is
//     ignored for state. stall is still computed from current state.
//   - Counts never wrap: the stall rule guarantees inc only when count<max or dec same cycle.
//   - Latency: issue of writer W at cycle n; a dependent reader stalls from n+1 until
//     the cycle W's write-back is asserted (inclusive of acceptance that cycle).
// TESTING
//   1 rst; issue R3 write; next cycle read src1=R3 -> stall=1, busy_vec[3]=1
//   2 writeBackEn=1, Dest_wb=3 with reader waiting -> stall=0 that cycle, busy_vec[3]=0 next
//   3 issue 3 writes to R5 (count=3=max); 4th write to R5 -> stall=1;
//     repeat with same-cycle wb to R5 -> accepted, count stays 3
//   4 writeBackEn Dest_wb=7 with count[7]=0 -> wb_underflow=1, stays 1 after flush, cleared by rst
//   5 issue_dest=14 / src1=15 with any state -> no stall, busy_vec unchanged
//   6 counts R1=2, R2=1; flush=1 with simultaneous issue to R1 -> all counts 0, busy_vec=0 next cycle

Source files
------------

// File: rtl/reg_hazard_scoreboard.sv
// RAW hazard scoreboard: per-register pending-write counts gate instruction issue.
// A write-back landing in the same cycle resolves the hazard because the register file writes on the falling edge.
module reg_hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 14,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                src2_used,
    input  logic                issue_wb_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic                writeBackEn,
    input  logic [ADDR_W-1:0]   Dest_wb,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_underflow
);

    localparam int unsigned      IdxN   = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] count_q, count_d;
    logic [NUM_REGS-1:0]            busy_q, busy_d;
    logic                           uf_q, uf_d;
    logic [NUM_REGS-1:0]            inc_vec, dec_vec, uf_vec;

    // Padded to the full index space so untracked indices read as never pending / never full.
    logic [IdxN-1:0] pend_full, at_max_full;

    always_comb begin
        pend_full   = '0;
        at_max_full = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend_full[i]   = (count_q[i] != '0)
                           & ~(writeBackEn & (Dest_wb == ADDR_W'(i)) & (count_q[i] == CNT_W'(1)));
            at_max_full[i] = (count_q[i] == CntMax);
        end
    end

    assign stall = issue_valid & (pend_full[src1]
                 | (src2_used & pend_full[src2])
                 | (issue_wb_en & at_max_full[issue_dest]
                    & ~(writeBackEn & (Dest_wb == issue_dest))));

    assign issue_fire = issue_valid & ~stall;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        uf_vec  = '0;
        busy_d  = '0;
        count_d = count_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_fire & issue_wb_en & (issue_dest == ADDR_W'(i));
            dec_vec[i] = writeBackEn & (Dest_wb == ADDR_W'(i)) & (count_q[i] != '0);
            uf_vec[i]  = writeBackEn & (Dest_wb == ADDR_W'(i)) & (count_q[i] == '0)
                       & ~inc_vec[i];
            count_d[i] = count_q[i] + CNT_W'(inc_vec[i]) - CNT_W'(dec_vec[i]);
        end
        if (flush) begin
            count_d = '0;
        end
        uf_d = uf_q | (~flush & (|uf_vec));
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_d[i] = (count_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            busy_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            uf_q    <= uf_d;
        end
    end

    assign busy_vec     = busy_q;
    assign wb_underflow = uf_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Bench for reg_hazard_scoreboard: directed scenarios followed by random traffic,
// all checked against a count-per-register reference model.
module tb_reg_hazard_scoreboard;

    localparam int NREG = 14;
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, src2_used, issue_wb_en, writeBackEn;
    logic [3:0]  src1, src2, issue_dest, Dest_wb;
    logic        stall, issue_fire, wb_underflow;
    logic [13:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    int cnt [16];
    bit uf_m;

    logic        last_stall;
    logic [13:0] last_busy;
    logic        last_uf;

    always #5 clk = ~clk;

    reg_hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (issue_valid),
        .src1        (src1),
        .src2        (src2),
        .src2_used   (src2_used),
        .issue_wb_en (issue_wb_en),
        .issue_dest  (issue_dest),
        .writeBackEn (writeBackEn),
        .Dest_wb     (Dest_wb),
        .stall       (stall),
        .issue_fire  (issue_fire),
        .busy_vec    (busy_vec),
        .wb_underflow(wb_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pend(int r, bit wbe, int dwb);
        if (r >= NREG) return 1'b0;
        return cnt[r] != 0 && !(wbe && dwb == r && cnt[r] == 1);
    endfunction

    // One clock: drive, check combinational outputs, clock, update model, check registered outputs.
    task automatic step(input bit r, input bit f, input bit iv, input logic [3:0] s1,
                        input logic [3:0] s2, input bit s2u, input bit wen,
                        input logic [3:0] d, input bit wbe, input logic [3:0] dwb);
        bit          es, ef, do_inc, do_dec, do_uf;
        logic [13:0] eb;
        int          di, wi;
        rst = r; flush = f; issue_valid = iv; src1 = s1; src2 = s2; src2_used = s2u;
        issue_wb_en = wen; issue_dest = d; writeBackEn = wbe; Dest_wb = dwb;
        di = int'(d);
        wi = int'(dwb);
        #1;
        es = iv && (m_pend(int'(s1), wbe, wi) || (s2u && m_pend(int'(s2), wbe, wi))
             || (wen && di < NREG && cnt[di] == MAXC && !(wbe && wi == di)));
        ef = iv && !es;
        chk("stall", 32'(stall), 32'(es));
        chk("issue_fire", 32'(issue_fire), 32'(ef));
        last_stall = stall;
        @(posedge clk);
        if (r) begin
            foreach (cnt[k]) cnt[k] = 0;
            uf_m = 1'b0;
        end else if (f) begin
            foreach (cnt[k]) cnt[k] = 0;
        end else begin
            do_inc = ef && wen && di < NREG;
            do_dec = wbe && wi < NREG && cnt[wi] != 0;
            do_uf  = wbe && wi < NREG && cnt[wi] == 0 && !(do_inc && di == wi);
            if (do_uf) uf_m = 1'b1;
            if (do_inc) cnt[di] = cnt[di] + 1;
            if (do_dec) cnt[wi] = cnt[wi] - 1;
        end
        for (int k = 0; k < NREG; k++) eb[k] = (cnt[k] != 0);
        #1;
        chk("busy_vec", 32'(busy_vec), 32'(eb));
        chk("wb_underflow", 32'(wb_underflow), 32'(uf_m));
        last_busy = busy_vec;
        last_uf   = wb_underflow;
    endtask

    initial begin
        bit          r, f, iv, s2u, wen, wbe;
        logic [3:0]  s1, s2, d, dwb;
        foreach (cnt[k]) cnt[k] = 0;
        uf_m = 1'b0;
        #1;

        // Reset
        step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        chk("reset_busy", 32'(last_busy), 32'd0);

        // RAW on R3, then same-cycle write-back releases the reader
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd3, 0, 4'd0);
        chk("t1_busy3", 32'(last_busy[3]), 32'd1);
        step(0, 0, 1, 4'd3, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        chk("t1_reader_stall", 32'(last_stall), 32'd1);
        step(0, 0, 1, 4'd3, 4'd0, 0, 0, 4'd0, 1, 4'd3);
        chk("t2_resolve_stall", 32'(last_stall), 32'd0);
        chk("t2_busy3", 32'(last_busy[3]), 32'd0);

        // Saturate R5, blocked 4th write, then accepted with same-cycle write-back
        repeat (3) step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 4'd0);
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 4'd0);
        chk("t3_full_stall", 32'(last_stall), 32'd1);
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd5, 1, 4'd5);
        chk("t3_full_wb_stall", 32'(last_stall), 32'd0);
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 4'd0);
        chk("t3_still_full", 32'(last_stall), 32'd1);

        // Underflow on R7 is sticky through flush, cleared by reset
        step(0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 1, 4'd7);
        chk("t4_uf_set", 32'(last_uf), 32'd1);
        step(0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        chk("t4_uf_after_flush", 32'(last_uf), 32'd1);
        step(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        chk("t4_uf_after_rst", 32'(last_uf), 32'd0);

        // Untracked indices
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd2, 0, 4'd0);
        step(0, 0, 1, 4'd15, 4'd14, 1, 1, 4'd14, 0, 4'd0);
        chk("t5_stall", 32'(last_stall), 32'd0);
        chk("t5_busy", 32'(last_busy), 32'h0004);
        step(0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 1, 4'd15);
        chk("t5_no_uf", 32'(last_uf), 32'd0);

        // Flush with simultaneous issue
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd1, 0, 4'd0);
        step(0, 0, 1, 4'd0, 4'd0, 0, 1, 4'd1, 0, 4'd0);
        step(0, 1, 1, 4'd0, 4'd0, 0, 1, 4'd1, 0, 4'd0);
        chk("t6_flush_busy", 32'(last_busy), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 79) == 0);
            f   = ($urandom_range(0, 29) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            s1  = 4'($urandom_range(0, 15));
            s2  = 4'($urandom_range(0, 15));
            s2u = 1'($urandom_range(0, 1));
            wen = ($urandom_range(0, 2) != 0);
            d   = 4'($urandom_range(0, 7));
            wbe = ($urandom_range(0, 2) == 0);
            dwb = ($urandom_range(0, 1) == 0) ? s1 : 4'($urandom_range(0, 15));
            step(r, f, iv, s1, s2, s2u, wen, d, wbe, dwb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
